req_agent: RTL
==============

REQ_AGENT -- requirements
Module: req_agent

Interface
REQ-001 SHALL have parameter N, default 8: number of requester channels.
REQ-002 SHALL have parameter CNT_W, default 4: pending-job counter width per channel.
REQ-003 SHALL have parameter STARVE_LIMIT, default 16: wait cycles before starvation is flagged.
REQ-004 SHALL have port clk  input  1: single clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst  input  1: synchronous active-high reset.
REQ-006 SHALL have port job_valid  input  1: job enqueue strobe.
REQ-007 SHALL have port job_ch  input  $clog2(N): target channel of the job.
REQ-008 SHALL have port job_ready  output  1: job can be accepted this cycle.
REQ-009 SHALL have port req  output  N: request vector to the round-robin arbiter.
REQ-010 SHALL have port grant  input  N: grant vector from the arbiter.
REQ-011 SHALL have port done_valid  output  1: one job completed, registered.
REQ-012 SHALL have port done_ch  output  $clog2(N): channel of the completed job.
REQ-013 SHALL have port err_onehot  output  1: sticky flag, multi-hot grant seen.
REQ-014 SHALL have port err_spurious  output  1: sticky flag, grant to a non-requesting channel.
REQ-015 SHALL have port starve  output  N: per-channel starvation flag.

Function
REQ-016 SHALL keep per channel a pending count 0..2^CNT_W-1; req[i] SHALL be 1 exactly when pending[i]!=0, derived from registers only (no input-to-req path).
REQ-017 SHALL drive job_ready = (pending[job_ch] != max), combinational from job_ch and registered state; a job SHALL be accepted when job_valid && job_ready.
REQ-018 SHALL treat a grant as valid when grant is one-hot and the granted bit has req set; a valid grant SHALL decrement that pending count by 1 at the next edge.
REQ-019 SHALL assert done_valid for exactly one cycle, one cycle after a valid grant, with done_ch = granted index.
REQ-020 SHALL, when a job is accepted and a valid grant hits the same channel in one cycle, leave that pending count unchanged and still emit done_valid.
REQ-021 SHALL, when grant has two or more bits set, decrement nothing, emit no done_valid, and set err_onehot.
REQ-022 SHALL, when grant is one-hot but req of that bit is 0, change nothing, emit no done_valid, and set err_spurious.
REQ-023 SHALL treat grant == 0 as idle with no effect.
REQ-024 SHALL keep per channel a wait counter: increment while req[i]=1 and not validly granted, saturating at STARVE_LIMIT; clear on valid grant to i or when req[i]=0.
REQ-025 SHALL assert starve[i] while wait[i] >= STARVE_LIMIT.

Reset
REQ-026 SHALL on rst clear all pending and wait counters; req=0, done_valid=0, done_ch=0, err_onehot=0, err_spurious=0, starve=0 at the first edge with rst high.
REQ-027 SHALL give rst priority over job acceptance and grants in the same cycle; jobs in flight are discarded.
REQ-028 SHALL clear error flags only by rst.

Configuration
REQ-029 SHALL, with macro REQ_AGENT_STARVE_EN defined, build the wait counters and starve logic per REQ-024/025.
REQ-030 SHALL, without REQ_AGENT_STARVE_EN, omit the wait counters and tie starve to 0; all other behaviour is identical.

Structure
REQ-031 SHALL place N, CH_W=$clog2(N), CNT_W and STARVE_LIMIT defaults in shared package arb_pkg.
REQ-032 SHALL implement one channel (pending counter, wait counter, req bit) as sub-module req_chan, instantiated N times; error detection and done registers stay in req_agent.

Verification
REQ-033 Reset: rst=1 for 2 cycles with job_valid=1 -> req=8'h00, starve=0, both errors 0.
REQ-034 Enqueue: jobs to ch 0,3,7 -> req=8'b1000_1001; grant=8'h08 for one cycle -> next cycle done_valid=1, done_ch=3, req=8'b1000_0001.
REQ-035 Full: 15 jobs to ch 2 (CNT_W=4) -> job_ready=0 for job_ch=2 and a 16th job is refused; simultaneous job plus grant=8'h04 with pending=5 -> pending stays 5, done_ch=2.
REQ-036 Errors: grant=8'h11 -> err_onehot=1, no done_valid; grant=8'h40 with req[6]=0 -> err_spurious=1; both stay set until rst.
REQ-037 Starvation (macro defined): req[5]=1 held 16 cycles with grant=0 -> starve[5]=1; grant=8'h20 -> starve[5]=0 next cycle; without the macro, starve stays 0 throughout.
REQ-038 Round-robin loop: connect the 8-bit arbiter, preload 2 jobs on every channel -> 16 done_valid pulses, no errors, and no starve with STARVE_LIMIT=16.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared defaults for the request agent and its channel slices
package arb_pkg;
   localparam int N_DEF            = 8;
   localparam int CH_W_DEF         = $clog2(N_DEF);
   localparam int CNT_W_DEF        = 4;
   localparam int STARVE_LIMIT_DEF = 16;
endpackage

// File: rtl/req_chan.sv
// req_chan: one channel slice (pending counter, optional wait counter, req bit); macro REQ_AGENT_STARVE_EN
module req_chan
   import arb_pkg::*;
#(
   parameter int CNT_W        = CNT_W_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output logic req,
   output logic full,
   output logic starve
);
   logic [CNT_W-1:0] pending;
   assign req  = pending != '0;
   assign full = &pending;
   // pending count: accept and grant in the same cycle cancel out
   always_ff @(posedge clk) begin
      if (rst) pending <= '0;
      else if (inc && !dec) pending <= pending + 1'b1;
      else if (dec && !inc) pending <= pending - 1'b1;
   end
`ifdef REQ_AGENT_STARVE_EN
   localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);
   logic [WAIT_W-1:0] wait_cnt;
   assign starve = wait_cnt >= LIMIT;
   // wait counter: counts ungranted request cycles, saturating at the limit
   always_ff @(posedge clk) begin
      if (rst || !req || dec) wait_cnt <= '0;
      else if (wait_cnt < LIMIT) wait_cnt <= wait_cnt + 1'b1;
   end
`else
   assign starve = 1'b0;
`endif
endmodule

// File: rtl/req_agent.sv
// req_agent: per-channel job queueing toward a round-robin arbiter with grant checking; macro REQ_AGENT_STARVE_EN
module req_agent
   import arb_pkg::*;
#(
   parameter int N            = N_DEF,
   parameter int CNT_W        = CNT_W_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 job_valid,
   input  logic [$clog2(N)-1:0] job_ch,
   output logic                 job_ready,
   output logic [N-1:0]         req,
   input  logic [N-1:0]         grant,
   output logic                 done_valid,
   output logic [$clog2(N)-1:0] done_ch,
   output logic                 err_onehot,
   output logic                 err_spurious,
   output logic [N-1:0]         starve
);
   localparam int CH_W = $clog2(N);
   logic [N-1:0]    full;
   logic            one_hot, hit, grant_ok, multi;
   logic [CH_W-1:0] gidx;
   assign job_ready = !full[job_ch];
   assign one_hot   = $onehot(grant);
   assign multi     = $countones(grant) > 1;
   assign hit       = |(grant & req);
   assign grant_ok  = one_hot && hit;
   // encode the granted index
   always_comb begin
      gidx = '0;
      for (int k = 0; k < N; k++) gidx = grant[k] ? CH_W'(k) : gidx;
   end
   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_ch
         req_chan #(.CNT_W(CNT_W), .STARVE_LIMIT(STARVE_LIMIT)) u_chan (
            .clk    (clk),
            .rst    (rst),
            .inc    (job_valid && job_ready && job_ch == CH_W'(i)),
            .dec    (grant_ok && grant[i]),
            .req    (req[i]),
            .full   (full[i]),
            .starve (starve[i])
         );
      end
   endgenerate
   // completion pulse and sticky grant-error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         done_valid   <= 1'b0;
         done_ch      <= '0;
         err_onehot   <= 1'b0;
         err_spurious <= 1'b0;
      end else begin
         done_valid   <= grant_ok;
         done_ch      <= grant_ok ? gidx : done_ch;
         err_onehot   <= err_onehot | multi;
         err_spurious <= err_spurious | (one_hot && !hit);
      end
   end
endmodule
